// File: rtl/st_disp.sv
`default_nettype none
// ============================================================================
//  Module      : st_disp
//  Description : Status display for the main state machine. Registers the
//                state / sub-state codes once, then drives an LED bar, a
//                4-digit multiplexed 7-segment display, a buzzer and a
//                state-change pulse/counter. Every output is registered.
//
//  Ports
//    clk         in   1  sole clock, rising edge
//    rst         in   1  synchronous active-high reset
//    state       in   4  main state code (0..6 valid, 7..15 invalid)
//    state_deep  in   3  sub-state code
//    led         out  8  LED bar, active-high
//    seg         out  8  segments {dp,g,f,e,d,c,b,a}, active-low
//    dig         out  4  digit select, active-low, one-hot-low
//    beep        out  1  buzzer enable, active-high
//    chg         out  1  one-cycle pulse per detected state change
//    chg_cnt     out  8  number of state changes since reset (wraps)
//
//  Revision    : 1.0  initial release
// ============================================================================
module st_disp #(
    parameter int SCAN_DIV  = 1000,      // clk cycles per digit-scan step
    parameter int BLINK_DIV = 25000000,  // clk cycles per blink half-period
    parameter int BEEP_CYC  = 5000000    // beep length after a change
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic [2:0] state_deep,
    output logic [7:0] led,
    output logic [7:0] seg,
    output logic [3:0] dig,
    output logic       beep,
    output logic       chg,
    output logic [7:0] chg_cnt
);

    localparam int c_SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int c_BEEP_W  = $clog2(BEEP_CYC + 1);

    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
    localparam logic [c_BEEP_W-1:0]  c_BEEP_LOAD  = c_BEEP_W'(BEEP_CYC);

    localparam logic [3:0] c_ST_RST   = 4'd0;
    localparam logic [3:0] c_ST_STOP  = 4'd1;
    localparam logic [3:0] c_ST_SLEEP = 4'd2;
    localparam logic [3:0] c_ST_LIGHT = 4'd3;
    localparam logic [3:0] c_ST_DRAW  = 4'd4;
    localparam logic [3:0] c_ST_ERASE = 4'd5;
    localparam logic [3:0] c_ST_COLOR = 4'd6;

    // Active-low hex glyphs, decimal point off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Input stage. These registers are deliberately not reset: they keep
    // sampling during reset so that the first compare after release sees
    // the real current state and does not report a spurious change.
    // ------------------------------------------------------------------
    logic [3:0] r_state_q;
    logic [2:0] r_deep_q;
    logic [3:0] r_prev_state;

    always_ff @(posedge clk) begin
        r_state_q    <= state;
        r_deep_q     <= state_deep;
        r_prev_state <= r_state_q;
    end

    // ------------------------------------------------------------------
    // Registered control / output state
    // ------------------------------------------------------------------
    logic                 r_valid;
    logic                 r_chg;
    logic [7:0]           r_chg_cnt;
    logic [c_BEEP_W-1:0]  r_beep_cnt;
    logic                 r_beep;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_ph;
    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]           r_dig_idx;
    logic [7:0]           r_led;
    logic [7:0]           r_seg;
    logic [3:0]           r_dig;

    logic                w_chg;
    logic                w_invalid;
    logic [c_BEEP_W-1:0] w_beep_nxt;
    logic [7:0]          w_led;
    logic [7:0]          w_seg;
    logic [3:0]          w_dig;

    // valid gates the very first compare after reset.
    assign w_chg     = r_valid && (r_state_q != r_prev_state);
    assign w_invalid = (r_state_q > c_ST_COLOR);

    always_comb begin
        w_beep_nxt = '0;
        if (w_chg) begin
            w_beep_nxt = c_BEEP_LOAD;
        end else if (r_beep_cnt != '0) begin
            w_beep_nxt = r_beep_cnt - 1'b1;
        end
    end

    always_comb begin
        w_led = 8'h00;
        case (r_state_q)
            c_ST_RST:   w_led = r_deep_q[0] ? 8'h00 : 8'hFF;
            c_ST_STOP:  w_led = 8'h81;
            c_ST_SLEEP: w_led = 8'h00;
            c_ST_LIGHT, c_ST_DRAW, c_ST_ERASE, c_ST_COLOR:
                        w_led = 8'd1 << r_state_q;
            default:    w_led = r_blink_ph ? 8'h55 : 8'hAA;
        endcase
    end

    // Segment data and digit strobe come from the same index so both
    // change on the same edge.
    always_comb begin
        w_seg = 8'hFF;
        case (r_dig_idx)
            2'd0:    w_seg = hex_glyph(r_state_q) & (w_invalid ? 8'h7F : 8'hFF);
            2'd1:    w_seg = hex_glyph({1'b0, r_deep_q});
            2'd2:    w_seg = hex_glyph(r_chg_cnt[3:0]);
            default: w_seg = hex_glyph(r_chg_cnt[7:4]);
        endcase
    end

    assign w_dig = ~(4'b0001 << r_dig_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_chg       <= 1'b0;
            r_chg_cnt   <= 8'h00;
            r_beep_cnt  <= '0;
            r_beep      <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
            r_scan_cnt  <= '0;
            r_dig_idx   <= 2'd0;
            r_led       <= 8'h00;
            r_seg       <= 8'hFF;
            r_dig       <= 4'hF;
        end else begin
            r_valid    <= 1'b1;
            r_chg      <= w_chg;
            if (w_chg) begin
                r_chg_cnt <= r_chg_cnt + 8'd1;
            end
            r_beep_cnt <= w_beep_nxt;
            r_beep     <= (w_beep_nxt != '0);

            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            if (r_scan_cnt == c_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_dig_idx  <= r_dig_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            r_led <= w_led;
            r_seg <= w_seg;
            r_dig <= w_dig;
        end
    end

    assign led     = r_led;
    assign seg     = r_seg;
    assign dig     = r_dig;
    assign beep    = r_beep;
    assign chg     = r_chg;
    assign chg_cnt = r_chg_cnt;

endmodule
`default_nettype wire
